// File: rtl/br_lite_inject_sched.sv
// Round-robin injection scheduler for the BrLite LOCAL input port.
// Flit layout (LSB first): source[15:0], target[31:16], service[33:32], id[41:34], payload[73:42].
module br_lite_inject_sched #(
  parameter logic [15:0] ADDRESS = 16'h0000,
  parameter int          NREQ    = 4,
  localparam int ADDR_W = 16,
  localparam int SVC_W  = 2,
  localparam int ID_W   = 8,
  localparam int PAY_W  = 32,
  localparam int FLIT_W = 2 * ADDR_W + SVC_W + ID_W + PAY_W
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         src_req_i,
  input  logic [NREQ*ADDR_W-1:0]  src_target_i,
  input  logic [NREQ*SVC_W-1:0]   src_service_i,
  input  logic [NREQ*PAY_W-1:0]   src_payload_i,
  output logic [NREQ-1:0]         src_done_o,
  output logic                    src_err_o,
  input  logic                    br_busy_i,
  output logic [FLIT_W-1:0]       br_flit_o,
  output logic                    br_req_o,
  input  logic                    br_ack_i,
  output logic [ID_W-1:0]         id_o
);

  localparam int IDXW = $clog2(NREQ);

  localparam logic [SVC_W-1:0] BR_SVC_CLEAR = 2'd0;
  localparam logic [SVC_W-1:0] BR_SVC_ALL   = 2'd1;
  localparam logic [SVC_W-1:0] BR_SVC_TGT   = 2'd2;

  typedef enum logic [2:0] {IDLE, CHECK, REQ, RELEASE, DONE} state_e;

  state_e            state_q, state_d;
  logic [FLIT_W-1:0] flit_q;
  logic [IDXW-1:0]   sel_q;
  logic [IDXW-1:0]   last_gnt_q;
  logic [ID_W-1:0]   id_q;

  logic              gnt_found;
  logic [IDXW-1:0]   gnt_idx;
  logic [IDXW-1:0]   cand;
  logic              grant;
  logic              id_inc;
  logic [SVC_W-1:0]  flit_svc;
  logic              svc_ok;

  // First requester strictly after last_gnt, wrapping; scanning last_gnt itself last.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDXW'((int'(last_gnt_q) + k) % NREQ);
      if (!gnt_found && src_req_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign flit_svc = flit_q[2*ADDR_W +: SVC_W];
  assign svc_ok   = (flit_svc == BR_SVC_ALL) || (flit_svc == BR_SVC_TGT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    br_req_o   = 1'b0;
    src_done_o = '0;
    src_err_o  = 1'b0;
    grant      = 1'b0;
    id_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          grant   = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!svc_ok) begin
          state_d = DONE;
        end else if (!br_busy_i) begin
          state_d = REQ;
        end
      end
      REQ: begin
        br_req_o = 1'b1;
        if (br_ack_i) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!br_ack_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        src_done_o[sel_q] = 1'b1;
        src_err_o         = !svc_ok;
        id_inc            = svc_ok;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The flit is only rewritten on a grant, so it holds from CHECK through DONE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flit_q     <= '0;
      sel_q      <= '0;
      last_gnt_q <= IDXW'(NREQ - 1);
      id_q       <= '0;
    end else begin
      if (grant) begin
        flit_q     <= {src_payload_i[int'(gnt_idx)*PAY_W +: PAY_W],
                       id_q,
                       src_service_i[int'(gnt_idx)*SVC_W +: SVC_W],
                       src_target_i[int'(gnt_idx)*ADDR_W +: ADDR_W],
                       ADDRESS};
        sel_q      <= gnt_idx;
        last_gnt_q <= gnt_idx;
      end
      if (id_inc) begin
        id_q <= id_q + ID_W'(1);
      end
    end
  end

  assign br_flit_o = flit_q;
  assign id_o      = id_q;

endmodule

// File: tb/tb_br_lite_inject_sched.sv
// Directed bench for br_lite_inject_sched; the bench plays the requesters and the router.
module tb_br_lite_inject_sched;

  localparam logic [15:0] ADDR = 16'hA5C3;
  localparam int NREQ = 4;
  localparam logic [1:0] SVC_CLEAR = 2'd0;
  localparam logic [1:0] SVC_ALL   = 2'd1;
  localparam logic [1:0] SVC_TGT   = 2'd2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [3:0]    src_req_i;
  logic [63:0]   src_target_i;
  logic [7:0]    src_service_i;
  logic [127:0]  src_payload_i;
  logic [3:0]    src_done_o;
  logic          src_err_o;
  logic          br_busy_i;
  logic [73:0]   br_flit_o;
  logic          br_req_o;
  logic          br_ack_i;
  logic [7:0]    id_o;

  int total = 0;
  int bad = 0;
  int rises = 0;
  logic req_prev = 1'b0;

  br_lite_inject_sched #(.ADDRESS(ADDR), .NREQ(NREQ)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .src_req_i(src_req_i), .src_target_i(src_target_i),
    .src_service_i(src_service_i), .src_payload_i(src_payload_i),
    .src_done_o(src_done_o), .src_err_o(src_err_o),
    .br_busy_i(br_busy_i), .br_flit_o(br_flit_o),
    .br_req_o(br_req_o), .br_ack_i(br_ack_i), .id_o(id_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (br_req_o && !req_prev) rises <= rises + 1;
    req_prev <= br_req_o;
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic [1:0] svc, input logic [15:0] tgt,
                               input logic [31:0] pay);
    src_service_i[idx*2 +: 2]   = svc;
    src_target_i[idx*16 +: 16]  = tgt;
    src_payload_i[idx*32 +: 32] = pay;
    src_req_i[idx]              = 1'b1;
  endtask

  function automatic logic [73:0] expFlit(input logic [1:0] svc, input logic [15:0] tgt,
                                          input logic [7:0] id, input logic [31:0] pay);
    return {pay, id, svc, tgt, ADDR};
  endfunction

  // Router side: ack 'delay' cycles after req is seen, hold ack 'hold' cycles, then await done.
  task automatic serveTxn(input int delay, input int hold, output int got_sel,
                          output int fall_wait, output logic [73:0] flit_seen);
    int n;
    got_sel = -1;
    fall_wait = -1;
    flit_seen = '0;
    n = 0;
    while (br_req_o !== 1'b1 && n < 200) begin tick(); n++; end
    if (br_req_o !== 1'b1) begin
      checkOutput("req_timeout", 128'(br_req_o), 128'(1));
      return;
    end
    flit_seen = br_flit_o;
    repeat (delay) tick();
    br_ack_i = 1'b1;
    repeat (hold) tick();
    br_ack_i = 1'b0;
    n = 0;
    while (src_done_o == 4'b0 && n < 50) begin tick(); n++; end
    fall_wait = n;
    if (src_done_o == 4'b0) begin
      checkOutput("done_timeout", 128'(src_done_o), 128'(1));
      return;
    end
    for (int i = 0; i < NREQ; i++) if (src_done_o[i]) got_sel = i;
    checkOutput("err_low", 128'(src_err_o), 128'(0));
    src_req_i[got_sel] = 1'b0;
  endtask

  task automatic doReset();
    rst_ni = 1'b0;
    br_ack_i = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
  endtask

  initial begin
    int sel, fw, r0, n;
    logic [73:0] fl;
    logic saw;
    src_req_i = '0;
    src_target_i = '0;
    src_service_i = '0;
    src_payload_i = '0;
    br_busy_i = 1'b0;
    br_ack_i = 1'b0;
    rst_ni = 1'b0;
    repeat (2) tick();
    checkOutput("rst_req", 128'(br_req_o), 128'(0));
    checkOutput("rst_done", 128'(src_done_o), 128'(0));
    checkOutput("rst_err", 128'(src_err_o), 128'(0));
    checkOutput("rst_flit", 128'(br_flit_o), 128'(0));
    checkOutput("rst_id", 128'(id_o), 128'(0));
    rst_ni = 1'b1;
    tick();

    // Single targeted request
    applyStimulus(0, SVC_TGT, 16'h0102, 32'd5);
    serveTxn(2, 1, sel, fw, fl);
    checkOutput("single_sel", 128'(sel), 128'(0));
    checkOutput("single_flit", 128'(fl), 128'(expFlit(SVC_TGT, 16'h0102, 8'd0, 32'd5)));
    tick();
    checkOutput("single_id", 128'(id_o), 128'(1));

    // Round robin from a fresh reset
    doReset();
    for (int k = 0; k < 4; k++)
      applyStimulus(k, SVC_ALL, 16'(16'h1000 + k), 32'(32'hC0DE0000 + k));
    for (int k = 0; k < 4; k++) begin
      serveTxn(1, 1, sel, fw, fl);
      checkOutput("rr_sel", 128'(sel), 128'(k));
      checkOutput("rr_flit", 128'(fl),
                  128'(expFlit(SVC_ALL, 16'(16'h1000 + k), 8'(k), 32'(32'hC0DE0000 + k))));
    end
    tick();
    applyStimulus(3, SVC_ALL, 16'h2003, 32'hBEEF0003);
    applyStimulus(1, SVC_TGT, 16'h2001, 32'hBEEF0001);
    serveTxn(1, 1, sel, fw, fl);
    checkOutput("rr2_sel_a", 128'(sel), 128'(1));
    checkOutput("rr2_flit_a", 128'(fl), 128'(expFlit(SVC_TGT, 16'h2001, 8'd4, 32'hBEEF0001)));
    serveTxn(1, 1, sel, fw, fl);
    checkOutput("rr2_sel_b", 128'(sel), 128'(3));
    checkOutput("rr2_flit_b", 128'(fl), 128'(expFlit(SVC_ALL, 16'h2003, 8'd5, 32'hBEEF0003)));
    tick();

    // Busy hold
    br_busy_i = 1'b1;
    applyStimulus(2, SVC_ALL, 16'h3333, 32'h33);
    saw = 1'b0;
    repeat (50) begin tick(); if (br_req_o) saw = 1'b1; end
    checkOutput("busy_no_req", 128'(saw), 128'(0));
    br_busy_i = 1'b0;
    tick();
    checkOutput("req_after_busy", 128'(br_req_o), 128'(1));
    serveTxn(0, 1, sel, fw, fl);
    checkOutput("busy_sel", 128'(sel), 128'(2));
    checkOutput("busy_flit", 128'(fl), 128'(expFlit(SVC_ALL, 16'h3333, 8'd6, 32'h33)));
    tick();
    checkOutput("busy_id", 128'(id_o), 128'(7));

    // Rejected service
    applyStimulus(1, SVC_CLEAR, 16'h4444, 32'h44);
    saw = 1'b0;
    n = 0;
    while (src_done_o == 4'b0 && n < 20) begin tick(); n++; if (br_req_o) saw = 1'b1; end
    checkOutput("rej_done", 128'(src_done_o), 128'(4'b0010));
    checkOutput("rej_err", 128'(src_err_o), 128'(1));
    checkOutput("rej_no_req", 128'(saw), 128'(0));
    src_req_i[1] = 1'b0;
    tick();
    checkOutput("rej_id", 128'(id_o), 128'(7));
    checkOutput("rej_err_gone", 128'(src_err_o), 128'(0));

    // Ack shapes: single-cycle, then held for 10 cycles
    r0 = rises;
    applyStimulus(0, SVC_ALL, 16'h5555, 32'h55);
    serveTxn(0, 1, sel, fw, fl);
    checkOutput("ack1_sel", 128'(sel), 128'(0));
    checkOutput("ack1_wait", 128'(fw), 128'(1));
    repeat (2) tick();
    checkOutput("ack1_rises", 128'(rises - r0), 128'(1));
    r0 = rises;
    applyStimulus(0, SVC_ALL, 16'h6666, 32'h66);
    serveTxn(0, 10, sel, fw, fl);
    checkOutput("ack10_wait", 128'(fw), 128'(1));
    checkOutput("ack10_flit", 128'(fl), 128'(expFlit(SVC_ALL, 16'h6666, 8'd8, 32'h66)));
    repeat (2) tick();
    checkOutput("ack10_rises", 128'(rises - r0), 128'(1));
    checkOutput("ack10_id", 128'(id_o), 128'(9));

    // Reset in the middle of REQ
    applyStimulus(3, SVC_ALL, 16'h7777, 32'h77);
    n = 0;
    while (br_req_o !== 1'b1 && n < 50) begin tick(); n++; end
    checkOutput("mid_req_high", 128'(br_req_o), 128'(1));
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("mid_rst_req", 128'(br_req_o), 128'(0));
    checkOutput("mid_rst_id", 128'(id_o), 128'(0));
    applyStimulus(0, SVC_TGT, 16'h8080, 32'h80);
    applyStimulus(2, SVC_ALL, 16'h8282, 32'h82);
    tick();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    serveTxn(1, 1, sel, fw, fl);
    checkOutput("post_rst_sel", 128'(sel), 128'(0));
    checkOutput("post_rst_flit", 128'(fl), 128'(expFlit(SVC_TGT, 16'h8080, 8'd0, 32'h80)));
    src_req_i = '0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
